// File: rtl/risc_v_32_mem_stage.sv
// ---------------------------------------------------------------------------
// risc_v_32_mem_stage
// Memory-access stage of the RV32I pipeline, directly downstream of EX.
// It holds one instruction in the EX/MEM register. For a load or store it
// drives a request/acknowledge data-memory access and stalls EX until the
// access completes. Store data is replicated across byte lanes and qualified
// with byte enables. Load data is taken from its lane and then sign- or
// zero-extended. The result goes to WB through registered outputs.
//
// Ports
//   clk, clrn        rising-edge clock, asynchronous active-low reset
//   ex_valid/ready   EX handshake (ex_ready is combinational)
//   ex_alu_out       ALU result / full byte address for memory ops
//   ex_m_addr        memory address from EX (addressing uses ex_alu_out)
//   ex_d_t_mem       store data (rs2)
//   ex_wreg/wmem/rmem  register write / store / load
//   ex_func3         access width and signedness
//   ex_rd            destination register
//   dm_req/we/addr/be/wdata  data-memory request, held stable until dm_ack
//   dm_rdata, dm_ack         read data and completion from memory
//   wb_valid/wreg/rd/data    registered write-back result (valid is a pulse)
// ---------------------------------------------------------------------------
module risc_v_32_mem_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_m_addr,
  input  logic [31:0] ex_d_t_mem,
  input  logic        ex_wreg,
  input  logic        ex_wmem,
  input  logic        ex_rmem,
  input  logic [2:0]  ex_func3,
  input  logic [4:0]  ex_rd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ALU   = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // EX/MEM pipeline register
  logic [31:0] r_m_alu_out;
  logic [31:0] r_m_d_t_mem;
  logic        r_m_wreg;
  logic        r_m_wmem;
  logic        r_m_rmem;
  logic [2:0]  r_m_func3;
  logic [4:0]  r_m_rd;

  // Write-back register
  logic        r_wb_valid;
  logic        r_wb_wreg;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_done;
  logic        w_accept;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  // The MEM stage forms its address from the ALU result. The separate EX
  // address is accepted on the interface but is not needed here.
  logic w_unused;
  assign w_unused = ^ex_m_addr;

  // Byte enables for the access width. A misaligned half or word is forced
  // to an aligned lane.
  function automatic logic [3:0] f_byte_en(input logic [1:0] size,
                                           input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes. The byte enables choose the lane.
  function automatic logic [31:0] f_store_data(input logic [1:0]  size,
                                               input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Take the addressed byte or half from the lane, then sign- or
  // zero-extend it. A func3 value that does not encode a load behaves as lw.
  function automatic logic [31:0] f_load_data(input logic [31:0] rdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'd0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign w_done   = (r_state == S_ALU) | ((r_state == S_MEM) & dm_ack);
  assign ex_ready = (r_state == S_EMPTY) | w_done;
  assign w_accept = ex_valid & ex_ready;

  // Next state: the slot refills whenever it is empty or its instruction
  // completes this cycle. This gives back-to-back issue with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == S_EMPTY) || w_done) begin
      if (w_accept)
        w_state_nxt = (ex_rmem | ex_wmem) ? S_MEM : S_ALU;
      else
        w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Stage boundary: EX -> MEM
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_m_alu_out <= '0;
      r_m_d_t_mem <= '0;
      r_m_wreg    <= 1'b0;
      r_m_wmem    <= 1'b0;
      r_m_rmem    <= 1'b0;
      r_m_func3   <= '0;
      r_m_rd      <= '0;
    end else if (w_accept) begin
      r_m_alu_out <= ex_alu_out;
      r_m_d_t_mem <= ex_d_t_mem;
      r_m_wreg    <= ex_wreg;
      r_m_wmem    <= ex_wmem;
      r_m_rmem    <= ex_rmem;
      r_m_func3   <= ex_func3;
      r_m_rd      <= ex_rd;
    end
  end

  assign w_lane      = r_m_alu_out[1:0];
  assign w_be        = f_byte_en(r_m_func3[1:0], w_lane);
  assign w_wdata     = f_store_data(r_m_func3[1:0], r_m_d_t_mem);
  assign w_load_data = f_load_data(dm_rdata, r_m_func3, w_lane);

  // Every request field comes from the EX/MEM register, so each one is held
  // while the access is stalled. Byte enables are gated so that they read
  // zero while the stage is idle.
  assign dm_req   = (r_state == S_MEM);
  assign dm_we    = r_m_wmem;
  assign dm_addr  = {r_m_alu_out[31:2], 2'b00};
  assign dm_be    = dm_req ? w_be : 4'b0000;
  assign dm_wdata = w_wdata;

  // Stage boundary: MEM -> WB
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wb_valid <= 1'b0;
      r_wb_wreg  <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_done;
      if (w_done) begin
        r_wb_rd   <= r_m_rd;
        // x0 is never written, and stores never write the register file.
        r_wb_wreg <= r_m_wreg & ~r_m_wmem & (r_m_rd != 5'd0);
        r_wb_data <= r_m_rmem ? w_load_data : r_m_alu_out;
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_wreg  = r_wb_wreg;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_risc_v_32_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_risc_v_32_mem_stage
// Directed-vector bench for the MEM stage. Inputs change 1 ns after a rising
// edge. Registered outputs are sampled in that same window, and the
// combinational response is sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_risc_v_32_mem_stage;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_m_addr;
  logic [31:0] ex_d_t_mem;
  logic        ex_wreg;
  logic        ex_wmem;
  logic        ex_rmem;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_rd;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        wb_valid;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  risc_v_32_mem_stage dut (
    .clk        (clk),
    .clrn       (clrn),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_alu_out (ex_alu_out),
    .ex_m_addr  (ex_m_addr),
    .ex_d_t_mem (ex_d_t_mem),
    .ex_wreg    (ex_wreg),
    .ex_wmem    (ex_wmem),
    .ex_rmem    (ex_rmem),
    .ex_func3   (ex_func3),
    .ex_rd      (ex_rd),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_be      (dm_be),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .wb_valid   (wb_valid),
    .wb_wreg    (wb_wreg),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] alu, input logic [31:0] d,
                         input logic wreg, input logic wmem, input logic rmem,
                         input logic [2:0] f3, input logic [4:0] rd);
    ex_valid   = 1'b1;
    ex_alu_out = alu;
    ex_m_addr  = alu;
    ex_d_t_mem = d;
    ex_wreg    = wreg;
    ex_wmem    = wmem;
    ex_rmem    = rmem;
    ex_func3   = f3;
    ex_rd      = rd;
  endtask

  // Issue one load. The memory acknowledges it in the cycle after
  // acceptance. The task then checks the byte enables and the result.
  task automatic do_load(input string tag, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    present(addr, 32'h0, 1'b1, 1'b0, 1'b1, f3, 5'd5);
    step();
    ex_valid = 1'b0;
    dm_rdata = 32'h80FF7F01;
    dm_ack   = 1'b1;
    #1;
    check({tag, "_be"}, {28'd0, dm_be}, {28'd0, exp_be});
    check({tag, "_we"}, {31'd0, dm_we}, 32'd0);
    step();
    dm_ack = 1'b0;
    check({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp_data);
  endtask

  initial begin
    ex_valid   = 1'b0;
    ex_alu_out = '0;
    ex_m_addr  = '0;
    ex_d_t_mem = '0;
    ex_wreg    = 1'b0;
    ex_wmem    = 1'b0;
    ex_rmem    = 1'b0;
    ex_func3   = '0;
    ex_rd      = '0;
    dm_rdata   = '0;
    dm_ack     = 1'b0;

    // Reset values
    #1 clrn = 1'b0;
    #1;
    check("rst_dm_req",   {31'd0, dm_req},   32'd0);
    check("rst_dm_we",    {31'd0, dm_we},    32'd0);
    check("rst_dm_be",    {28'd0, dm_be},    32'd0);
    check("rst_dm_addr",  dm_addr,           32'd0);
    check("rst_dm_wdata", dm_wdata,          32'd0);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data",  wb_data,           32'd0);
    step();
    step();
    clrn = 1'b1;

    // dm_ack while idle is ignored
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    check("idle_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("idle_ack_dm_req",   {31'd0, dm_req},   32'd0);

    // Back-to-back ALU ops
    present(32'h11, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd1);
    #1 check("b2b_ready0", {31'd0, ex_ready}, 32'd1);
    step();
    present(32'h22, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd2);
    #1 check("b2b_ready1", {31'd0, ex_ready}, 32'd1);
    step();
    check("b2b_v1",    {31'd0, wb_valid}, 32'd1);
    check("b2b_d1",    wb_data,           32'h11);
    check("b2b_rd1",   {27'd0, wb_rd},    32'd1);
    check("b2b_wreg1", {31'd0, wb_wreg},  32'd1);
    present(32'h33, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd3);
    #1 check("b2b_ready2", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 1'b0;
    check("b2b_v2",  {31'd0, wb_valid}, 32'd1);
    check("b2b_d2",  wb_data,           32'h22);
    check("b2b_rd2", {27'd0, wb_rd},    32'd2);
    step();
    check("b2b_v3",  {31'd0, wb_valid}, 32'd1);
    check("b2b_d3",  wb_data,           32'h33);
    check("b2b_rd3", {27'd0, wb_rd},    32'd3);
    step();
    check("b2b_v_end", {31'd0, wb_valid}, 32'd0);

    // addi targeting x0
    present(32'h5, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd0);
    step();
    ex_valid = 1'b0;
    step();
    check("x0_valid", {31'd0, wb_valid}, 32'd1);
    check("x0_wreg",  {31'd0, wb_wreg},  32'd0);
    check("x0_data",  wb_data,           32'h5);
    step();

    // sb at lane 3, acknowledged one cycle after acceptance
    present(32'h1003, 32'h000000A5, 1'b0, 1'b1, 1'b0, 3'b000, 5'd0);
    step();
    ex_valid = 1'b0;
    #1;
    check("sb_req",   {31'd0, dm_req},   32'd1);
    check("sb_we",    {31'd0, dm_we},    32'd1);
    check("sb_addr",  dm_addr,           32'h1000);
    check("sb_be",    {28'd0, dm_be},    32'h8);
    check("sb_wdata", dm_wdata,          32'hA5A5A5A5);
    check("sb_stall", {31'd0, ex_ready}, 32'd0);
    step();
    check("sb_wb_valid", {31'd0, wb_valid}, 32'd0);
    dm_ack = 1'b1;
    #1 check("sb_ack_ready", {31'd0, ex_ready}, 32'd1);
    step();
    dm_ack = 1'b0;
    check("sb_wb_valid2", {31'd0, wb_valid}, 32'd1);
    check("sb_wb_wreg",   {31'd0, wb_wreg},  32'd0);
    check("sb_req_after", {31'd0, dm_req},   32'd0);

    // sh at lane 2, acknowledged in the acceptance cycle; upper data dropped
    present(32'h1002, 32'hABCD1234, 1'b0, 1'b1, 1'b0, 3'b001, 5'd0);
    step();
    ex_valid = 1'b0;
    dm_ack   = 1'b1;
    #1;
    check("sh_addr",  dm_addr,        32'h1000);
    check("sh_be",    {28'd0, dm_be}, 32'hC);
    check("sh_wdata", dm_wdata,       32'h12341234);
    step();
    dm_ack = 1'b0;
    check("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sh_wb_wreg",  {31'd0, wb_wreg},  32'd0);

    // Load extraction with dm_rdata = 0x80FF7F01
    do_load("lb3",  32'h2003, 3'b000, 4'b1000, 32'hFFFFFF80);
    do_load("lbu3", 32'h2003, 3'b100, 4'b1000, 32'h00000080);
    do_load("lh2",  32'h2002, 3'b001, 4'b1100, 32'hFFFF80FF);
    do_load("lhu0", 32'h2000, 3'b101, 4'b0011, 32'h00007F01);
    do_load("lw",   32'h2000, 3'b010, 4'b1111, 32'h80FF7F01);
    step();

    // Stall: lw then add, with the ack three cycles late
    present(32'h3000, 32'h0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd7);
    step();
    present(32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", {31'd0, ex_ready}, 32'd0);
      check("stall_req",   {31'd0, dm_req},   32'd1);
      check("stall_addr",  dm_addr,           32'h3000);
      check("stall_be",    {28'd0, dm_be},    32'hF);
      check("stall_we",    {31'd0, dm_we},    32'd0);
      step();
      check("stall_wb",    {31'd0, wb_valid}, 32'd0);
    end
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    #1 check("stall_ack_ready", {31'd0, ex_ready}, 32'd1);
    step();
    dm_ack   = 1'b0;
    ex_valid = 1'b0;
    check("stall_wb1_valid", {31'd0, wb_valid}, 32'd1);
    check("stall_wb1_rd",    {27'd0, wb_rd},    32'd7);
    check("stall_wb1_data",  wb_data,           32'hCAFEF00D);
    check("stall_add_noreq", {31'd0, dm_req},   32'd0);
    step();
    check("stall_wb2_valid", {31'd0, wb_valid}, 32'd1);
    check("stall_wb2_rd",    {27'd0, wb_rd},    32'd8);
    check("stall_wb2_data",  wb_data,           32'h99);
    step();
    check("stall_wb_end", {31'd0, wb_valid}, 32'd0);

    // Reset during an outstanding access
    present(32'h4000, 32'h0, 1'b1, 1'b0, 1'b1, 3'b010, 5'd9);
    step();
    ex_valid = 1'b0;
    #1 check("rma_req_before", {31'd0, dm_req}, 32'd1);
    clrn = 1'b0;
    #1;
    check("rma_req",   {31'd0, dm_req},   32'd0);
    check("rma_valid", {31'd0, wb_valid}, 32'd0);
    check("rma_ready", {31'd0, ex_ready}, 32'd1);
    check("rma_be",    {28'd0, dm_be},    32'd0);
    #1 clrn = 1'b1;
    step();
    check("rma_req_after",   {31'd0, dm_req},   32'd0);
    check("rma_valid_after", {31'd0, wb_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/risc_v_32_mem_stage.md
# risc_v_32_mem_stage

Memory-access stage of the RV32I pipeline, directly downstream of EX. It registers EX results in an EX/MEM pipeline register and drives a data-memory request/acknowledge handshake, stalling EX until the access completes. Store data is lane-replicated with byte enables; load data is lane-extracted and sign/zero-extended. It presents a registered write-back result to the WB stage.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  stage can accept the EX instruction this cycle
- ex_alu_out  in  32  ALU result; for memory ops, the full byte address
- ex_m_addr  in  32  memory address from EX
- ex_d_t_mem  in  32  store data (rs2)
- ex_wreg / ex_wmem / ex_rmem  in  1 each  register write / store / load
- ex_func3  in  3  inst[14:12], access width and signedness
- ex_rd  in  5  destination register
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  32  word address, bits [1:0] always 0
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_rdata  in  32  read data, valid when dm_ack=1
- dm_ack  in  1  access completes this cycle
- wb_valid  out  1  write-back result valid (one-cycle pulse per instruction)
- wb_wreg  out  1  write register file
- wb_rd  out  5  destination register
- wb_data  out  32  write-back data

## Operation
- EX/MEM register (m_*) loads all ex_* fields on an edge where ex_valid && ex_ready.
- FSM state: S_EMPTY (no instruction held), S_ALU (non-memory op held), S_MEM (load/store held, access outstanding). mem_op = m_rmem | m_wmem.
- Done condition: S_ALU always; S_MEM when dm_ack=1; S_EMPTY never.
- ex_ready = (state == S_EMPTY) | done (combinational).
- Transitions on edge: done or S_EMPTY -> S_MEM if EX accepted with rmem|wmem, S_ALU if EX accepted otherwise, S_EMPTY if no accept. S_MEM without dm_ack stays S_MEM and holds m_*.
- dm_req = (state == S_MEM); dm_we = m_wmem; dm_addr = {m_alu_out[31:2],2'b00}. dm_* values are held constant while dm_req=1 and dm_ack=0.
- Lane = m_alu_out[1:0]. Width is selected by func3[1:0]: 00 byte, be = 0001<<lane, wdata = {4{d[7:0]}}; 01 half, be = lane[1] ? 1100 : 0011, wdata = {2{d[15:0]}}; 10/11 word, be = 1111, wdata = d. Loads drive the same be.
- Load data by func3: 000 lb sign-extends the selected byte; 100 lbu zero-extends it; 001 lh sign-extends half lane[1]; 101 lhu zero-extends it; all other values behave as lw.
- Misaligned low address bits are ignored (word/half forced aligned); no exception.
- Write-back registers update on every edge: wb_valid = done; if done, wb_rd = m_rd, wb_wreg = m_wreg & (m_rd != 0), and wb_data = extracted dm_rdata for loads, else m_alu_out (stores: wb_wreg = 0). When not done, wb_valid = 0 and the other wb_* fields hold.

## Timing
- Reset (clrn=0, asynchronous): state = S_EMPTY, m_* = 0, wb_valid = 0, wb_wreg = 0, wb_rd = 0, wb_data = 0. Hence dm_req = 0, dm_we = 0, dm_be = 0, dm_addr = 0, dm_wdata = 0, ex_ready = 1. Reset during an outstanding access drops dm_req immediately and discards the request.
- Non-memory op: accepted at edge N, wb_valid pulses in the cycle after edge N+1. Sustains 1 instruction per cycle.
- Memory op: accepted at edge N, dm_req=1 from N. If dm_ack comes k cycles later (k=0 is same cycle), wb_valid is high after edge N+1+k. With dm_ack held at 1, throughput is 1 per cycle.
- The cycle dm_ack=1 is also the cycle the next EX instruction is accepted (ex_ready=1); there is no bubble.
- dm_ack while dm_req=0 is ignored.

## Test plan
- Reset mid-access: lw issued, dm_ack held 0, clrn pulsed low -> dm_req=0 and wb_valid=0 immediately, ex_ready=1.
- Back-to-back ALU ops: alu_out 0x11, 0x22, 0x33, with rd=1,2,3 on consecutive cycles -> wb_valid for 3 consecutive cycles, data 0x11/0x22/0x33, ex_ready stays 1.
- sb: addr 0x1003, d=0xA5 -> dm_addr=0x1000, be=1000, wdata=0xA5A5A5A5, wb_wreg=0. sh: addr 0x1002, d=0x1234 -> be=1100, wdata=0x12341234.
- Loads with dm_rdata=0x80FF7F01: lb at lane 3 -> 0xFFFFFF80; lbu at lane 3 -> 0x00000080; lh at lane 2 -> 0xFFFF80FF; lhu at lane 0 -> 0x00007F01; lw -> 0x80FF7F01.
- Stall: lw then add presented, dm_ack delayed 3 cycles -> ex_ready=0 for 3 cycles, dm_* stable, add accepted in the ack cycle, wb results in order.
- rd=0: addi with rd=0, alu_out 5 -> wb_valid=1, wb_wreg=0.
